// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with a first-word-fall-through byte FIFO.
// Framing errors and overruns are reported as sticky flags.
module uart_rx_buffered #(
   parameter int CLOCK_FREQ = 27000000,
   parameter int BIT_RATE   = 9600,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          rx,
   input  logic                          rd_en,
   output logic [7:0]                    rd_data,
   output logic                          empty,
   output logic                          full,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          frame_error,
   output logic                          overrun,
   input  logic                          clear_flags
);

   localparam int CLKS_PER_BIT = CLOCK_FREQ / BIT_RATE;
   localparam int AW           = $clog2(FIFO_DEPTH);
   localparam int CW           = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] STOP  = 3'd3;
   localparam logic [2:0] BREAK = 3'd4;

   logic          sync1, rx_s;
   logic [2:0]    state;
   logic [CW-1:0] clk_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift_reg;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;

   logic stop_sample, push, do_pop, do_push, fe_set, ov_set;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= rx;
         rx_s  <= sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         clk_cnt   <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state   <= START;
                  clk_cnt <= '0;
               end
            end
            START: begin
               if (clk_cnt == HALF_M1) begin
                  if (rx_s) begin
                     state <= IDLE;
                  end else begin
                     state   <= DATA;
                     clk_cnt <= '0;
                     bit_cnt <= '0;
                  end
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            DATA: begin
               if (clk_cnt == LAST) begin
                  clk_cnt   <= '0;
                  shift_reg <= {rx_s, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= STOP;
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            STOP: begin
               if (clk_cnt == LAST) begin
                  clk_cnt <= '0;
                  state   <= rx_s ? IDLE : BREAK;
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            BREAK: begin
               if (rx_s) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign stop_sample = (state == STOP) && (clk_cnt == LAST);
   assign push        = stop_sample && rx_s;
   assign fe_set      = stop_sample && !rx_s;

   assign count   = wr_ptr - rd_ptr;
   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(FIFO_DEPTH));
   assign do_pop  = rd_en && !empty;
   // When full, a simultaneous pop frees the head slot, which is the slot the push writes.
   assign do_push = push && (!full || do_pop);
   assign ov_set  = push && full && !do_pop;
   assign rd_data = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= shift_reg;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         frame_error <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
         if (fe_set)           frame_error <= 1'b1;
         else if (clear_flags) frame_error <= 1'b0;
         if (ov_set)           overrun <= 1'b1;
         else if (clear_flags) overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Randomized self-checking bench for uart_rx_buffered against a queue-based
// model of the receive FIFO and sticky flags.
module tb_uart_rx_buffered;

   localparam int DEPTH = 4;
   localparam int CPB   = 16;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       reset, rx, rd_en, clear_flags;
   logic [7:0] rd_data;
   logic       empty, full, frame_error, overrun;
   logic [2:0] count;

   int errors = 0;
   int checks = 0;

   logic [7:0] q[$];
   logic       m_fe, m_ov;

   always #5 clk = ~clk;

   uart_rx_buffered #(.CLOCK_FREQ(16), .BIT_RATE(1), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .rx(rx), .rd_en(rd_en), .rd_data(rd_data),
      .empty(empty), .full(full), .count(count), .frame_error(frame_error),
      .overrun(overrun), .clear_flags(clear_flags)
   );

   function automatic logic [7:0] exp_data();
      return (q.size() > 0) ? q[0] : 8'h00;
   endfunction

   function automatic logic [2:0] exp_count();
      return 3'(q.size());
   endfunction

   // Model of a received frame: stop=1 pushes (or overruns), stop=0 flags an error.
   task automatic model_frame(input logic [7:0] b, input logic stop, input logic popped);
      if (!stop) m_fe = 1'b1;
      else begin
         if (popped && q.size() > 0) void'(q.pop_front());
         if (q.size() == DEPTH) m_ov = 1'b1;
         else q.push_back(b);
      end
   endtask

   // Drives one frame; each cycle samples at the negedge, then updates inputs.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int pop_cyc,
                             input int clr_cyc, output int fall_cyc);
      logic e0;
      int   slot;
      e0 = empty;
      fall_cyc = -1;
      for (int cyc = 0; cyc < FRAME; cyc++) begin
         if (fall_cyc < 0 && e0 && !empty) fall_cyc = cyc;
         slot = cyc / CPB;
         if (slot == 0)      rx = 1'b0;
         else if (slot == 9) rx = stop;
         else                rx = b[slot-1];
         rd_en       = (cyc == pop_cyc);
         clear_flags = (cyc == clr_cyc);
         @(negedge clk);
      end
      rd_en = 1'b0;
      clear_flags = 1'b0;
   endtask

   task automatic pop_one();
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      if (q.size() > 0) void'(q.pop_front());
   endtask

   task automatic pulse_clear();
      clear_flags = 1'b1;
      @(negedge clk);
      clear_flags = 1'b0;
      m_fe = 1'b0;
      m_ov = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; rx = 1'b1; rd_en = 1'b0; clear_flags = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      q.delete(); m_fe = 1'b0; m_ov = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
      checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_fe got=%b exp=0", frame_error); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ov got=%b exp=0", overrun); end
   endtask

   task automatic test_single_byte();
      logic [7:0] b;
      int fc;
      for (int i = 0; i < 3; i++) begin
         b = (i == 0) ? 8'hA5 : 8'($urandom);
         send_frame(b, 1'b1, -1, -1, fc);
         model_frame(b, 1'b1, 1'b0);
         checks++; if (fc < 153 || fc > 157) begin errors++; $display("FAIL single_latency byte=%h got_cycle=%0d exp=153..157", b, fc); end
         checks++; if (rd_data !== exp_data()) begin errors++; $display("FAIL single_data got=%h exp=%h", rd_data, exp_data()); end
         checks++; if (count !== exp_count()) begin errors++; $display("FAIL single_count got=%0d exp=%0d", count, exp_count()); end
         pop_one();
         checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_pop_empty got=%b exp=1", empty); end
         checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL single_pop_data got=%h exp=00", rd_data); end
      end
   endtask

   task automatic test_glitch();
      logic [7:0] b;
      int fc;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL glitch_empty got=%b exp=1", empty); end
      checks++; if (frame_error !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL glitch_flags got=%b%b exp=00", frame_error, overrun); end
      b = 8'($urandom);
      send_frame(b, 1'b1, -1, -1, fc);
      model_frame(b, 1'b1, 1'b0);
      checks++; if (rd_data !== exp_data()) begin errors++; $display("FAIL glitch_next_data got=%h exp=%h", rd_data, exp_data()); end
      pop_one();
   endtask

   task automatic test_frame_error();
      int fc;
      logic [7:0] b;
      send_frame(8'h3C, 1'b0, -1, -1, fc);
      model_frame(8'h3C, 1'b0, 1'b0);
      repeat (40) @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      checks++; if (frame_error !== m_fe) begin errors++; $display("FAIL fe_set got=%b exp=%b", frame_error, m_fe); end
      checks++; if (count !== exp_count()) begin errors++; $display("FAIL fe_count got=%0d exp=%0d", count, exp_count()); end
      send_frame(8'h81, 1'b1, -1, -1, fc);
      model_frame(8'h81, 1'b1, 1'b0);
      checks++; if (rd_data !== exp_data() || count !== exp_count()) begin errors++; $display("FAIL fe_recover got=%h/%0d exp=%h/%0d", rd_data, count, exp_data(), exp_count()); end
      pulse_clear();
      checks++; if (frame_error !== m_fe) begin errors++; $display("FAIL fe_clear got=%b exp=%b", frame_error, m_fe); end
      pop_one();
      // A clear in the same cycle as a new framing error must lose.
      b = 8'($urandom);
      send_frame(b, 1'b0, -1, 154, fc);
      model_frame(b, 1'b0, 1'b0);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      checks++; if (frame_error !== m_fe) begin errors++; $display("FAIL fe_priority got=%b exp=%b", frame_error, m_fe); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fe_priority_empty got=%b exp=1", empty); end
      pulse_clear();
   endtask

   task automatic test_overrun();
      int fc;
      logic [7:0] b;
      for (int i = 0; i < 5; i++) begin
         b = 8'($urandom);
         send_frame(b, 1'b1, -1, -1, fc);
         model_frame(b, 1'b1, 1'b0);
      end
      checks++; if (full !== 1'b1 || count !== exp_count()) begin errors++; $display("FAIL ov_full got=%b/%0d exp=1/%0d", full, count, exp_count()); end
      checks++; if (overrun !== m_ov) begin errors++; $display("FAIL ov_flag got=%b exp=%b", overrun, m_ov); end
      for (int i = 0; i < DEPTH; i++) begin
         checks++; if (rd_data !== exp_data()) begin errors++; $display("FAIL ov_read%0d got=%h exp=%h", i, rd_data, exp_data()); end
         pop_one();
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ov_drain_empty got=%b exp=1", empty); end
      pulse_clear();
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ov_clear got=%b exp=0", overrun); end
   endtask

   task automatic test_collision();
      int fc;
      logic [7:0] b;
      for (int i = 0; i < DEPTH; i++) begin
         b = 8'($urandom);
         send_frame(b, 1'b1, -1, -1, fc);
         model_frame(b, 1'b1, 1'b0);
      end
      b = 8'h55;
      send_frame(b, 1'b1, 154, -1, fc);
      model_frame(b, 1'b1, 1'b1);
      checks++; if (count !== exp_count() || full !== 1'b1) begin errors++; $display("FAIL coll_count got=%0d/%b exp=%0d/1", count, full, exp_count()); end
      checks++; if (overrun !== m_ov) begin errors++; $display("FAIL coll_overrun got=%b exp=%b", overrun, m_ov); end
      for (int i = 0; i < DEPTH; i++) begin
         checks++; if (rd_data !== exp_data()) begin errors++; $display("FAIL coll_read%0d got=%h exp=%h", i, rd_data, exp_data()); end
         if (i == DEPTH - 1) begin
            checks++; if (rd_data !== 8'h55) begin errors++; $display("FAIL coll_last got=%h exp=55", rd_data); end
         end
         pop_one();
      end
   endtask

   task automatic test_reset_mid_frame();
      int fc;
      logic [7:0] b, pre;
      pre = 8'($urandom);
      send_frame(pre, 1'b1, -1, -1, fc);
      model_frame(pre, 1'b1, 1'b0);
      b = 8'($urandom);
      for (int cyc = 0; cyc < 72; cyc++) begin
         rx = (cyc < CPB) ? 1'b0 : b[cyc/CPB - 1];
         @(negedge clk);
      end
      reset = 1'b0;
      rx = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      q.delete(); m_fe = 1'b0; m_ov = 1'b0;
      repeat (40) @(negedge clk);
      checks++; if (empty !== 1'b1 || count !== 3'd0 || rd_data !== 8'h00) begin errors++; $display("FAIL midreset_fifo got=%b/%0d/%h exp=1/0/00", empty, count, rd_data); end
      checks++; if (frame_error !== 1'b0 || overrun !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL midreset_flags got=%b%b%b exp=000", frame_error, overrun, full); end
      send_frame(8'h5A, 1'b1, -1, -1, fc);
      model_frame(8'h5A, 1'b1, 1'b0);
      checks++; if (rd_data !== exp_data() || count !== exp_count()) begin errors++; $display("FAIL midreset_next got=%h/%0d exp=%h/%0d", rd_data, count, exp_data(), exp_count()); end
      pop_one();
   endtask

   task automatic test_back_to_back();
      int fc;
      logic [7:0] b;
      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom);
         send_frame(b, 1'b1, -1, -1, fc);
         model_frame(b, 1'b1, 1'b0);
      end
      rd_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (rd_data !== exp_data() || count !== exp_count()) begin errors++; $display("FAIL b2b_read%0d got=%h/%0d exp=%h/%0d", i, rd_data, count, exp_data(), exp_count()); end
         @(negedge clk);
         void'(q.pop_front());
      end
      rd_en = 1'b0;
      checks++; if (empty !== 1'b1 || rd_data !== 8'h00) begin errors++; $display("FAIL b2b_empty got=%b/%h exp=1/00", empty, rd_data); end
      pop_one();
      checks++; if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL pop_when_empty got=%0d/%b exp=0/1", count, empty); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single_byte();
      test_glitch();
      test_frame_error();
      test_overrun();
      test_collision();
      test_reset_mid_frame();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_buffered.md
# uart_rx_buffered

UART receive path with an integrated receive FIFO, the receiving end of the SoC's `tx`/`rx` serial link. It synchronises the asynchronous `rx` pin, frames 8N1 characters at `BIT_RATE`, and queues received bytes in a first-word-fall-through FIFO. The CPU-side bus or peripheral logic pops bytes with a single-cycle read strobe. Framing errors and overruns are reported as sticky flags.

## Interface
- `CLOCK_FREQ`, 27000000, system clock frequency in Hz
- `BIT_RATE`, 9600, baud rate; `CLKS_PER_BIT = CLOCK_FREQ / BIT_RATE` (integer division), minimum 4
- `FIFO_DEPTH`, 16, number of byte entries; power of two, ≥ 2

Ports:
- `clk`  in  1  system clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-low reset
- `rx`  in  1  asynchronous serial input; idle high
- `rd_en`  in  1  pop strobe; ignored when `empty`=1
- `rd_data`  out  8  head-of-FIFO byte; valid while `empty`=0; 0 when empty
- `empty`  out  1  FIFO holds no bytes
- `full`  out  1  FIFO holds `FIFO_DEPTH` bytes
- `count`  out  $clog2(FIFO_DEPTH)+1  current occupancy
- `frame_error`  out  1  sticky; set on a bad stop bit
- `overrun`  out  1  sticky; set when a byte is dropped because the FIFO is full
- `clear_flags`  in  1  one-cycle strobe; clears `frame_error` and `overrun`

## Operation
- **Reset values** (`reset`=0 at an edge): both synchroniser flops 1; state IDLE; bit counter and clock counter 0; FIFO pointers 0. Outputs after reset: `empty`=1, `full`=0, `count`=0, `rd_data`=0, `frame_error`=0, `overrun`=0. Reset aborts any frame in progress and discards FIFO contents.
- **Synchroniser:** `rx` passes through two flops to give `rx_s`. All FSM decisions use `rx_s` only.
- **FSM states:**
  - IDLE: `rx_s`=0 → START, clock counter cleared.
  - START: counts to `CLKS_PER_BIT/2 - 1`, then samples `rx_s`. Value 1 means a glitch → IDLE. Value 0 → DATA, with clock and bit counters cleared.
  - DATA: samples `rx_s` when the clock counter reaches `CLKS_PER_BIT-1`, then clears the counter. Bits are shifted in LSB first. After the 8th bit → STOP.
  - STOP: samples at `CLKS_PER_BIT-1`.
    - Sample 1: push the byte, then → IDLE.
    - Sample 0: set `frame_error`, discard the byte, then → BREAK.
  - BREAK: waits for `rx_s`=1, then → IDLE. A held-low line never produces a phantom frame.
- **Push/pop:**
  - Push when full and no pop in the same cycle: byte dropped, `overrun` set, FIFO unchanged.
  - Push and pop in the same cycle: both take effect, `count` unchanged. This also holds when full; no overrun is raised in that case.
  - Pop when empty: no effect.
- **Flags:** setting a flag has priority over `clear_flags` in the same cycle.
- **Count arithmetic:** `count` = wr_ptr − rd_ptr using pointers one bit wider than the address. Pointers wrap modulo 2·`FIFO_DEPTH`.

## Timing
- Let t0 be the first cycle in which `rx_s`=0 in IDLE, which is 2 cycles after `rx` falls.
- The start-bit sample occurs at t0 + `CLKS_PER_BIT/2`, ±1 cycle.
- Data bit k is sampled at t0 + `CLKS_PER_BIT/2` + (k+1)·`CLKS_PER_BIT`, ±1 cycle.
- The stop-bit sample occurs at t0 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`, ±1 cycle.
- Push latency: `empty`, `count` and `rd_data` update on the edge after the stop-bit sample.
- Pop: `rd_data` shows the next entry (or 0) on the edge after the `rd_en` cycle, and `count` decrements on that same edge. Back-to-back `rd_en` on consecutive cycles is supported.
- Flag latency: flags assert on the edge after the stop sample that triggered them.
- Throughput: back-to-back frames with no idle time are accepted. The FSM is back in IDLE before the next start bit's midpoint.

## Test plan
All scenarios use `CLOCK_FREQ`=16, `BIT_RATE`=1 (`CLKS_PER_BIT`=16), `FIFO_DEPTH`=4 unless noted.
- **Single byte:** send 0xA5 → `empty` falls within 2 cycles after the stop midpoint; `rd_data`=0xA5, `count`=1. Then pulse `rd_en` → `empty`=1, `rd_data`=0.
- **Glitch:** drive `rx` low for 4 cycles, then high → no push, flags 0, FSM back in IDLE.
- **Framing error:** send 0x3C with the stop bit 0, hold low for 40 cycles, then high → `frame_error`=1, `count`=0, no extra frames. Then send 0x81 → received correctly. Pulse `clear_flags` → `frame_error`=0.
- **Overrun:** send 0x01..0x05 with no reads → `full`=1, `count`=4, `overrun`=1. Reads return 01, 02, 03, 04, then `empty`=1.
- **Push/pop collision at full:** with the FIFO full, assert `rd_en` in the push cycle of a 5th byte 0x55 → `count` stays 4, `overrun`=0. The last read returns 0x55.
- **Reset mid-frame:** assert `reset`=0 for 1 cycle during data bit 3 → all outputs return to reset values. The next frame, 0x5A, is received correctly.
